// File: rtl/control_pkg.sv
// Shared types for the instruction decoder / sequencing controller:
// opcodes, ALU op codes, controller states and the bundled control word.
package control_pkg;

  localparam int OPC_W    = 4;
  localparam int ALU_OP_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD   = 4'h8,
    OP_HALT  = 4'h9,
    OP_LOAD  = 4'hA,
    OP_STORE = 4'hB,
    OP_CLEAR = 4'hC,
    OP_SKIP  = 4'hD,
    OP_JUMP  = 4'hE
  } opcode_e;

  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_CLR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_CMP  = 4'h4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SKIP   = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic                reg_write_enable;
    logic [ALU_OP_W-1:0] alu_op;
    logic                pc_write_enable;
    logic                jump_enable;
    logic                halt;
  } ctrl_t;

  // Control word for a plain PC increment with no side effects.
  localparam ctrl_t CTRL_NOP  = '{1'b0, ALU_NOP, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_HALT = '{1'b0, ALU_NOP, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational opcode -> control word map; sequencing lives in control_unit.
module instr_decoder
  import control_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ADD:   ctrl = '{1'b1, ALU_ADD,  1'b1, 1'b0, 1'b0};
      OP_HALT:  ctrl = CTRL_HALT;
      OP_LOAD:  ctrl = '{1'b1, ALU_PASS, 1'b1, 1'b0, 1'b0};
      OP_STORE: ctrl = '{1'b0, ALU_PASS, 1'b1, 1'b0, 1'b0};
      OP_CLEAR: ctrl = '{1'b1, ALU_CLR,  1'b1, 1'b0, 1'b0};
      OP_SKIP:  ctrl = '{1'b0, ALU_CMP,  1'b1, 1'b0, 1'b0};
      OP_JUMP:  ctrl = '{1'b0, ALU_NOP,  1'b1, 1'b1, 1'b0};
      // undefined and X opcodes fall through as NOP
      default:  ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Registered decoder + RUN/SKIP/HALTED sequencer; outputs follow the
// instruction sampled on the previous rising edge.
module control_unit
  import control_pkg::*;
#(
  parameter int INSTR_W       = 16,
  parameter int ALU_OP_W_PORT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       instruction,
  output logic                     reg_write_enable,
  output logic [ALU_OP_W_PORT-1:0] alu_op,
  output logic                     pc_write_enable,
  output logic                     jump_enable,
  output logic                     halt
);

  ctrl_state_e      state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
  logic [OPC_W-1:0] opcode;
  logic             unused_operand;

  assign opcode         = instruction[INSTR_W-1 -: OPC_W];
  assign unused_operand = ^instruction[INSTR_W-OPC_W-1:0];

  instr_decoder u_dec (
    .opcode (opcode),
    .ctrl   (dec_ctrl)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = dec_ctrl;
    case (state_q)
      ST_RUN: begin
        if (opcode == OP_HALT)      state_d = ST_HALTED;
        else if (opcode == OP_SKIP) state_d = ST_SKIP;
      end
      ST_SKIP: begin
        // squashed slot: advance the PC only, whatever the opcode was
        ctrl_d  = CTRL_NOP;
        state_d = ST_RUN;
      end
      ST_HALTED: ctrl_d = CTRL_HALT;
      default: begin
        ctrl_d  = CTRL_NOP;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign reg_write_enable = ctrl_q.reg_write_enable;
  assign alu_op           = ALU_OP_W_PORT'(ctrl_q.alu_op);
  assign pc_write_enable  = ctrl_q.pc_write_enable;
  assign jump_enable      = ctrl_q.jump_enable;
  assign halt             = ctrl_q.halt;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed plan followed by a modelled random run.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        reg_write_enable, pc_write_enable, jump_enable, halt;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q[$];
  string      tag_q[$];
  int         ms;  // model state: 0 RUN, 1 SKIP, 2 HALTED

  control_unit dut (
    .clk              (clk),
    .reset            (reset),
    .instruction      (instruction),
    .reg_write_enable (reg_write_enable),
    .alu_op           (alu_op),
    .pc_write_enable  (pc_write_enable),
    .jump_enable      (jump_enable),
    .halt             (halt)
  );

  always #5 clk = ~clk;

  // packed as {rwe, alu_op[3:0], pwe, jump, halt}
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] ins, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    @(negedge clk);
    reset       = r;
    instruction = ins;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = {reg_write_enable, alu_op, pc_write_enable, jump_enable, halt};
    chk(tag_q.pop_front(), got, sb_q.pop_front());
  endtask

  function automatic logic [7:0] model(input logic r, input logic [3:0] op);
    logic [7:0] e;
    if (r) begin
      ms = 0;
      return 8'h00;
    end
    case (ms)
      2: e = 8'h01;
      1: begin e = 8'h04; ms = 0; end
      default: begin
        case (op)
          4'h8: e = 8'h8C;
          4'h9: begin e = 8'h01; ms = 2; end
          4'hA: e = 8'h94;
          4'hB: e = 8'h14;
          4'hC: e = 8'h9C;
          4'hD: begin e = 8'h24; ms = 1; end
          4'hE: e = 8'h06;
          default: e = 8'h04;
        endcase
      end
    endcase
    return e;
  endfunction

  initial begin
    logic        r;
    logic [15:0] ins;
    reset       = 1'b1;
    instruction = 16'h0000;

    drive(1'b1, 16'h8801, 8'h00, "reset");
    drive(1'b0, 16'h8801, 8'h8C, "add0");
    drive(1'b0, 16'h8801, 8'h8C, "add1");

    drive(1'b0, 16'hA803, 8'h94, "load");
    drive(1'b0, 16'hB804, 8'h14, "store");
    drive(1'b0, 16'hC805, 8'h9C, "clear");
    drive(1'b0, 16'hE807, 8'h06, "jump");
    drive(1'b0, 16'h0000, 8'h04, "nop0");
    drive(1'b0, 16'hF000, 8'h04, "nopF");
    drive(1'b0, 16'h8FFF, 8'h8C, "add_lowbits");

    drive(1'b0, 16'hD806, 8'h24, "skip");
    drive(1'b0, 16'hE807, 8'h04, "skip_squash_jump");
    drive(1'b0, 16'hE807, 8'h06, "jump_after_skip");
    drive(1'b0, 16'hD806, 8'h24, "skip2");
    drive(1'b0, 16'hD806, 8'h04, "skip_squash_skip");
    drive(1'b0, 16'hB804, 8'h14, "store_after_skip");

    drive(1'b0, 16'h9802, 8'h01, "halt");
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h8801, 8'h01, "halt_hold");
    drive(1'b1, 16'h8801, 8'h00, "halt_reset");
    drive(1'b0, 16'h8801, 8'h8C, "add_after_halt");

    drive(1'b0, 16'hD806, 8'h24, "shadow_skip");
    drive(1'b0, 16'h9802, 8'h04, "shadow_halt_squash");
    drive(1'b0, 16'h9802, 8'h01, "shadow_halt");
    drive(1'b1, 16'h0000, 8'h00, "reset2");

    drive(1'b0, 16'hD806, 8'h24, "midskip_skip");
    drive(1'b1, 16'hE807, 8'h00, "midskip_reset");
    drive(1'b0, 16'hE807, 8'h06, "midskip_jump");

    ms = 0;
    for (int i = 0; i < 80; i++) begin
      r   = ($urandom_range(0, 11) == 0);
      ins = 16'($urandom);
      if (ins[15:12] == 4'h9 && $urandom_range(0, 3) != 0) ins[15:12] = 4'h8;
      drive(r, ins, model(r, ins[15:12]), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
